// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared state encoding, default sizes and a counter-width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bit_serializer_pkg;

  // Serializer FSM encoding.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_t;

  // Defaults shared with the sequence-detector bench.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel-in valid/ready bus plus serial-out strobes of the serializer.
// Latency: n/a (wiring only).
// Backpressure: din_ready from the slave stalls the master; the serial side has no backpressure.
// Ports/signals: din, din_valid (master->slave); din_ready, ser_out, ser_valid,
//                bit_tick, last, busy (slave->master).
interface bit_serializer_if
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             bit_tick;
  logic             last;
  logic             busy;

  // Word source / serial-stream observer.
  modport master (
    output din, din_valid,
    input  din_ready, ser_out, ser_valid, bit_tick, last, busy
  );

  // The serializer itself.
  modport slave (
    input  din, din_valid,
    output din_ready, ser_out, ser_valid, bit_tick, last, busy
  );

endinterface

// File: rtl/bit_serializer_bit_tick_gen.sv
// bit_tick_gen: divider-counter clock enable, counts 0..DIV-1 and wraps.
// Latency: clear takes effect at the next edge; tick/wrap decode the registered count.
// Backpressure: none; clear holds the counter at zero.
// Ports: clk, rst (sync, active-high), clear (sync counter reset),
//        tick (count==0, first cycle of a period), wrap (count==DIV-1, last cycle of a period).
module bit_tick_gen
  import bit_serializer_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic wrap
);

  localparam int            CW       = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // With DIV=1 both strobes are permanently high: every cycle is a full period.
  assign tick = (r_cnt == '0);
  assign wrap = (r_cnt == CNT_LAST);

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel word in (valid/ready), one bit per DIV clocks out, with a one-word hold buffer.
// Latency: first bit on ser_out the cycle after the accepting edge; back-to-back words are gap-free.
// Backpressure: din_ready = !hold_full, decoded from registered state only.
// Ports: clk, rst (sync, active-high), bus (slave modport: din/din_valid/din_ready in,
//        ser_out/ser_valid/bit_tick/last/busy out).
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter int MSB_FIRST = 1
) (
  input logic             clk,
  input logic             rst,
  bit_serializer_if.slave bus
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [BW-1:0]    r_bit_idx;

  logic             w_xfer;
  logic             w_shifting;
  logic             w_tick;
  logic             w_wrap;
  logic             w_clear;
  logic             w_last_bit;
  logic             w_word_end;
  logic             w_cur_bit;
  logic [WIDTH-1:0] w_shift_next;

  assign w_shifting = (r_state == S_SHIFT);
  assign w_xfer     = bus.din_valid && bus.din_ready;
  assign w_last_bit = (r_bit_idx == BIT_LAST);
  assign w_word_end = w_shifting && w_wrap && w_last_bit;

  // The current bit always sits at the outgoing end of the shifter.
  assign w_cur_bit    = (MSB_FIRST != 0) ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shift_next = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_shift[WIDTH-1:1]};

  // Divider parked at zero while idle so the first period of a new word is full length.
  // A word-end reload needs no clear: the divider wraps to zero on that same edge.
  assign w_clear = !w_shifting;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick),
    .wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_bit_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_shift   <= bus.din;
            r_bit_idx <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_word_end) begin
            r_bit_idx <= '0;
            // Held word wins; a word arriving on this edge bypasses the empty hold buffer.
            if (r_hold_full) begin
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
            end else if (w_xfer) begin
              r_shift <= bus.din;
            end else begin
              r_shift <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            if (w_wrap) begin
              r_shift   <= w_shift_next;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
            // din_ready is low while hold is full, so this never overwrites a held word.
            if (w_xfer) begin
              r_hold      <= bus.din;
              r_hold_full <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.din_ready = !r_hold_full;
  assign bus.ser_valid = w_shifting;
  assign bus.ser_out   = w_shifting && w_cur_bit;
  assign bus.bit_tick  = w_shifting && w_tick;
  assign bus.last      = w_shifting && w_last_bit;
  assign bus.busy      = w_shifting || r_hold_full;

endmodule
